instr_fetch: RTL and testbench

Instruction fetch stage sitting directly downstream of the PC register. It samples the current PC, issues one instruction-memory read at a time over a request/grant/response handshake, and holds the returned word for decode. It back-pressures the PC register through `pc_en_o` and discards in-flight fetches when a jump or jr redirect is taken.

---
 rtl/instr_fetch.sv | 147 ++++++++++++++
 tb/tb_instr_fetch.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch stage placed directly after the PC register. It samples
// the current PC, issues a single instruction-memory read at a time over a
// request/grant/response handshake, and holds the returned word until decode
// accepts it. The PC register is advanced only through pc_en_o. A redirect
// (flush_i) discards any in-flight fetch.
//
// Ports
//   clk            : clock, rising edge
//   rst_n          : asynchronous active-low reset
//   pc_i           : current PC register output
//   pc_en_o        : PC register may load PC+4 on this edge
//   flush_i        : redirect taken; the PC register loads the target this edge
//   imem_req_o     : instruction-memory read request
//   imem_addr_o    : instruction-memory read address
//   imem_gnt_i     : request accepted this cycle
//   imem_rvalid_i  : read data valid
//   imem_rdata_i   : read data
//   if_valid_o     : an instruction is held for decode
//   if_ready_i     : decode accepts the held instruction
//   if_instr_o     : fetched instruction
//   if_pc_o        : address of if_instr_o
//   if_fault_o     : misaligned-PC fault marker (qualified by if_valid_o)
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] pc_i,
    output logic          pc_en_o,
    input  logic          flush_i,
    output logic          imem_req_o,
    output logic [AW-1:0] imem_addr_o,
    input  logic          imem_gnt_i,
    input  logic          imem_rvalid_i,
    input  logic [DW-1:0] imem_rdata_i,
    output logic          if_valid_o,
    input  logic          if_ready_i,
    output logic [DW-1:0] if_instr_o,
    output logic [AW-1:0] if_pc_o,
    output logic          if_fault_o
);

    typedef enum logic [2:0] {
        S_LOAD = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_DROP = 3'd3,
        S_FULL = 3'd4
    } state_t;

    state_t        state;
    logic [AW-1:0] req_addr;
    logic          drop_pend;

    // Outputs decode directly from registered state, so they are glitch-free
    // and stay stable while the memory withholds its grant.
    assign imem_req_o  = (state == S_REQ);
    assign imem_addr_o = req_addr;
    assign if_valid_o  = (state == S_FULL);

    // The PC advances only for a grant that will actually be delivered to
    // decode: a flush this cycle or a pending drop kills the fetch.
    assign pc_en_o = (state == S_REQ) & imem_gnt_i & ~flush_i & ~drop_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_LOAD;
            req_addr   <= '0;
            drop_pend  <= 1'b0;
            if_instr_o <= '0;
            if_pc_o    <= '0;
            if_fault_o <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    req_addr <= pc_i;
                    if (flush_i) begin
                        // PC is being redirected this edge; resample next cycle.
                        state <= S_LOAD;
                    end else if (pc_i[1:0] != 2'b00) begin
                        // Misaligned PC never reaches memory; present a fault.
                        state      <= S_FULL;
                        if_fault_o <= 1'b1;
                        if_instr_o <= '0;
                        if_pc_o    <= pc_i;
                    end else begin
                        state <= S_REQ;
                    end
                end

                S_REQ: begin
                    if (imem_gnt_i) begin
                        // A flush seen before or with the grant means the
                        // response belongs to the wrong path.
                        state     <= (flush_i || drop_pend) ? S_DROP : S_WAIT;
                        drop_pend <= 1'b0;
                    end else if (flush_i) begin
                        // Request cannot be withdrawn once raised; remember to
                        // throw its response away.
                        drop_pend <= 1'b1;
                    end
                end

                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        if (flush_i) begin
                            state <= S_LOAD;
                        end else begin
                            state      <= S_FULL;
                            if_instr_o <= imem_rdata_i;
                            if_pc_o    <= req_addr;
                            if_fault_o <= 1'b0;
                        end
                    end else if (flush_i) begin
                        state <= S_DROP;
                    end
                end

                S_DROP: begin
                    if (imem_rvalid_i) begin
                        state <= S_LOAD;
                    end
                end

                S_FULL: begin
                    // Flush wins over ready: the held word is on the wrong path.
                    if (flush_i) begin
                        state      <= S_LOAD;
                        if_fault_o <= 1'b0;
                    end else if (if_ready_i && !if_fault_o) begin
                        state <= S_LOAD;
                    end
                end

                default: begin
                    state <= S_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// Directed bench for instr_fetch. Inputs are driven 1 time unit after the
// rising edge, outputs are sampled 1 time unit later (mid-cycle), and every
// expected value is written out by hand in the step sequence below.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_i;
    logic        pc_en_o;
    logic        flush_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        if_valid_o;
    logic        if_ready_i;
    logic [31:0] if_instr_o;
    logic [31:0] if_pc_o;
    logic        if_fault_o;

    int n_cmp = 0;
    int n_err = 0;

    instr_fetch #(.AW(32), .DW(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_i          (pc_i),
        .pc_en_o       (pc_en_o),
        .flush_i       (flush_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .if_valid_o    (if_valid_o),
        .if_ready_i    (if_ready_i),
        .if_instr_o    (if_instr_o),
        .if_pc_o       (if_pc_o),
        .if_fault_o    (if_fault_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1 unit after the next rising edge, where inputs are driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush_i       = 1'b0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        if_ready_i    = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        pc_i  = 32'h0040_0000;
        idle_inputs();

        // ---------------- reset state ----------------
        tick(); tick();
        #1;
        chk("rst_req",   {31'b0, imem_req_o}, 32'h0);
        chk("rst_valid", {31'b0, if_valid_o}, 32'h0);
        chk("rst_pcen",  {31'b0, pc_en_o},    32'h0);
        chk("rst_instr", if_instr_o,          32'h0);
        chk("rst_pc",    if_pc_o,             32'h0);
        chk("rst_fault", {31'b0, if_fault_o}, 32'h0);
        chk("rst_addr",  imem_addr_o,         32'h0);

        // ---------------- straight fetch, zero-wait memory ----------------
        tick();
        rst_n = 1'b1;                        // c0 LOAD
        #1;
        chk("f0_c0_req",  {31'b0, imem_req_o}, 32'h0);
        chk("f0_c0_pcen", {31'b0, pc_en_o},    32'h0);
        tick();                              // c1 REQ
        imem_gnt_i = 1'b1;
        #1;
        chk("f0_c1_req",  {31'b0, imem_req_o}, 32'h1);
        chk("f0_c1_addr", imem_addr_o,         32'h0040_0000);
        chk("f0_c1_pcen", {31'b0, pc_en_o},    32'h1);
        tick();                              // c2 WAIT
        pc_i          = 32'h0040_0004;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'h2008_0005;
        #1;
        chk("f0_c2_pcen",  {31'b0, pc_en_o},    32'h0);
        chk("f0_c2_req",   {31'b0, imem_req_o}, 32'h0);
        chk("f0_c2_valid", {31'b0, if_valid_o}, 32'h0);
        tick();                              // c3 FULL
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        #1;
        chk("f0_c3_valid", {31'b0, if_valid_o}, 32'h1);
        chk("f0_c3_instr", if_instr_o,          32'h2008_0005);
        chk("f0_c3_pc",    if_pc_o,             32'h0040_0000);
        chk("f0_c3_fault", {31'b0, if_fault_o}, 32'h0);
        chk("f0_c3_pcen",  {31'b0, pc_en_o},    32'h0);

        // ---------------- decode back-pressure, 4 cycles ----------------
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            chk("bp_valid", {31'b0, if_valid_o}, 32'h1);
            chk("bp_instr", if_instr_o,          32'h2008_0005);
            chk("bp_pc",    if_pc_o,             32'h0040_0000);
            chk("bp_req",   {31'b0, imem_req_o}, 32'h0);
            chk("bp_pcen",  {31'b0, pc_en_o},    32'h0);
        end
        tick();
        if_ready_i = 1'b1;                   // consumed this edge
        #1;
        chk("bp_acc_valid", {31'b0, if_valid_o}, 32'h1);

        // ---------------- memory stalls: grant +2, rvalid +3 ----------------
        tick();                              // c0 LOAD
        if_ready_i = 1'b0;
        #1;
        chk("ms_c0_valid", {31'b0, if_valid_o}, 32'h0);
        chk("ms_c0_instr", if_instr_o,          32'h2008_0005);
        for (int i = 0; i < 2; i++) begin    // c1, c2 REQ without grant
            tick();
            #1;
            chk("ms_stall_req",  {31'b0, imem_req_o}, 32'h1);
            chk("ms_stall_addr", imem_addr_o,         32'h0040_0004);
            chk("ms_stall_pcen", {31'b0, pc_en_o},    32'h0);
        end
        tick();                              // c3 REQ with grant
        imem_gnt_i = 1'b1;
        #1;
        chk("ms_c3_addr", imem_addr_o,      32'h0040_0004);
        chk("ms_c3_pcen", {31'b0, pc_en_o}, 32'h1);
        tick();                              // c4 WAIT
        imem_gnt_i = 1'b0;
        pc_i       = 32'h0040_0008;
        for (int i = 0; i < 2; i++) begin    // c4, c5 no rvalid
            #1;
            chk("ms_wait_valid", {31'b0, if_valid_o}, 32'h0);
            chk("ms_wait_req",   {31'b0, imem_req_o}, 32'h0);
            tick();
        end
        #1;                                  // c6 no rvalid
        chk("ms_c6_valid", {31'b0, if_valid_o}, 32'h0);
        tick();                              // c7 rvalid
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'h8C09_0000;
        #1;
        chk("ms_c7_valid", {31'b0, if_valid_o}, 32'h0);
        tick();                              // c8 FULL
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        if_ready_i    = 1'b1;
        #1;
        chk("ms_c8_valid", {31'b0, if_valid_o}, 32'h1);
        chk("ms_c8_instr", if_instr_o,          32'h8C09_0000);
        chk("ms_c8_pc",    if_pc_o,             32'h0040_0004);

        // ---------------- flush while in WAIT ----------------
        tick();                              // c0 LOAD (pc 0x00400008)
        if_ready_i = 1'b0;
        tick();                              // c1 REQ, grant
        imem_gnt_i = 1'b1;
        #1;
        chk("fw_c1_addr", imem_addr_o,      32'h0040_0008);
        chk("fw_c1_pcen", {31'b0, pc_en_o}, 32'h1);
        tick();                              // c2 WAIT, flush to 0x00400040
        imem_gnt_i = 1'b0;
        flush_i    = 1'b1;
        pc_i       = 32'h0040_0040;
        #1;
        chk("fw_c2_pcen", {31'b0, pc_en_o}, 32'h0);
        tick();                              // c3 DROP
        flush_i = 1'b0;
        #1;
        chk("fw_c3_valid", {31'b0, if_valid_o}, 32'h0);
        chk("fw_c3_req",   {31'b0, imem_req_o}, 32'h0);
        tick();                              // c4 DROP, stale data returns
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hDEAD_BEEF;
        #1;
        chk("fw_c4_valid", {31'b0, if_valid_o}, 32'h0);
        tick();                              // c5 LOAD
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        #1;
        chk("fw_c5_valid", {31'b0, if_valid_o}, 32'h0);
        chk("fw_c5_instr", if_instr_o,          32'h8C09_0000);
        chk("fw_c5_req",   {31'b0, imem_req_o}, 32'h0);
        tick();                              // c6 REQ for the target
        imem_gnt_i = 1'b1;
        #1;
        chk("fw_c6_addr", imem_addr_o,      32'h0040_0040);
        chk("fw_c6_pcen", {31'b0, pc_en_o}, 32'h1);
        tick();                              // c7 WAIT
        imem_gnt_i    = 1'b0;
        pc_i          = 32'h0040_0044;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'h1111_1111;
        #1;
        chk("fw_c7_pcen", {31'b0, pc_en_o}, 32'h0);
        tick();                              // c8 FULL
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        if_ready_i    = 1'b1;
        #1;
        chk("fw_c8_valid", {31'b0, if_valid_o}, 32'h1);
        chk("fw_c8_instr", if_instr_o,          32'h1111_1111);
        chk("fw_c8_pc",    if_pc_o,             32'h0040_0040);

        // ---------------- flush in REQ before grant ----------------
        tick();                              // c0 LOAD (pc 0x00400044)
        if_ready_i = 1'b0;
        tick();                              // c1 REQ, flush, no grant
        flush_i = 1'b1;
        pc_i    = 32'h0040_0080;
        #1;
        chk("fr_c1_req",  {31'b0, imem_req_o}, 32'h1);
        chk("fr_c1_pcen", {31'b0, pc_en_o},    32'h0);
        tick();                              // c2 REQ held
        flush_i = 1'b0;
        #1;
        chk("fr_c2_req",  {31'b0, imem_req_o}, 32'h1);
        chk("fr_c2_addr", imem_addr_o,         32'h0040_0044);
        chk("fr_c2_pcen", {31'b0, pc_en_o},    32'h0);
        tick();                              // c3 late grant
        imem_gnt_i = 1'b1;
        #1;
        chk("fr_c3_addr", imem_addr_o,      32'h0040_0044);
        chk("fr_c3_pcen", {31'b0, pc_en_o}, 32'h0);
        tick();                              // c4 DROP, response arrives
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hBAD0_BAD0;
        #1;
        chk("fr_c4_valid", {31'b0, if_valid_o}, 32'h0);
        tick();                              // c5 LOAD
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        #1;
        chk("fr_c5_valid", {31'b0, if_valid_o}, 32'h0);
        chk("fr_c5_req",   {31'b0, imem_req_o}, 32'h0);
        tick();                              // c6 REQ for the target
        imem_gnt_i = 1'b1;
        #1;
        chk("fr_c6_addr", imem_addr_o,      32'h0040_0080);
        chk("fr_c6_pcen", {31'b0, pc_en_o}, 32'h1);
        tick();                              // c7 WAIT
        imem_gnt_i    = 1'b0;
        pc_i          = 32'h0040_0002;       // next PC misaligned
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'h2222_2222;
        tick();                              // c8 FULL
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        if_ready_i    = 1'b1;
        #1;
        chk("fr_c8_valid", {31'b0, if_valid_o}, 32'h1);
        chk("fr_c8_instr", if_instr_o,          32'h2222_2222);
        chk("fr_c8_pc",    if_pc_o,             32'h0040_0080);

        // ---------------- misaligned PC fault ----------------
        tick();                              // c0 LOAD (pc 0x00400002)
        #1;
        chk("mf_c0_req", {31'b0, imem_req_o}, 32'h0);
        for (int i = 0; i < 3; i++) begin    // FULL with fault, ready held high
            tick();
            #1;
            chk("mf_req",   {31'b0, imem_req_o}, 32'h0);
            chk("mf_valid", {31'b0, if_valid_o}, 32'h1);
            chk("mf_fault", {31'b0, if_fault_o}, 32'h1);
            chk("mf_instr", if_instr_o,          32'h0);
            chk("mf_pc",    if_pc_o,             32'h0040_0002);
            chk("mf_pcen",  {31'b0, pc_en_o},    32'h0);
        end
        tick();                              // flush out of the fault
        flush_i = 1'b1;
        pc_i    = 32'h0040_0106;             // redirect target also misaligned
        tick();                              // LOAD
        flush_i    = 1'b0;
        if_ready_i = 1'b0;
        #1;
        chk("mf_flush_valid", {31'b0, if_valid_o}, 32'h0);
        chk("mf_flush_req",   {31'b0, imem_req_o}, 32'h0);
        tick();                              // FULL, second fault
        #1;
        chk("mf2_valid", {31'b0, if_valid_o}, 32'h1);
        chk("mf2_fault", {31'b0, if_fault_o}, 32'h1);
        chk("mf2_pc",    if_pc_o,             32'h0040_0106);

        // ---------------- async reset mid-fault ----------------
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", {31'b0, if_valid_o}, 32'h0);
        chk("ar_fault", {31'b0, if_fault_o}, 32'h0);
        chk("ar_instr", if_instr_o,          32'h0);
        chk("ar_pc",    if_pc_o,             32'h0);
        chk("ar_req",   {31'b0, imem_req_o}, 32'h0);
        chk("ar_pcen",  {31'b0, pc_en_o},    32'h0);
        chk("ar_addr",  imem_addr_o,         32'h0);

        // ---------------- stale rvalid in LOAD is ignored ----------------
        tick();
        pc_i          = 32'h0040_0200;
        rst_n         = 1'b1;                // LOAD
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'h5555_5555;
        tick();                              // REQ, not FULL
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        #1;
        chk("st_valid", {31'b0, if_valid_o}, 32'h0);
        chk("st_req",   {31'b0, imem_req_o}, 32'h1);
        chk("st_addr",  imem_addr_o,         32'h0040_0200);
        chk("st_instr", if_instr_o,          32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
